// File: rtl/axis2fifo_packer.sv
// axis2fifo_packer: packs four AXI4-Stream video beats into one FDW-bit FIFO word
// and checks line/frame geometry on the way.
// Optional feature macro: AXIS2FIFO_LEVEL_THROTTLE_EN (throttle TREADY on FIFO fill level).
module axis2fifo_packer #(
  parameter int unsigned FDW               = 128,
  parameter int unsigned FAW               = 8,
  parameter int unsigned AXIS_DATA_WIDTH   = 32,
  parameter int unsigned PIXELS_HORIZONTAL = 1280,
  parameter int unsigned PIXELS_VERTICAL   = 1024,
  parameter int unsigned ALMOST_FULL_LEVEL = 240
) (
  input  logic                         S_AXIS_ACLK,
  input  logic                         S_AXIS_ARESET,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic [AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                         S_AXIS_TLAST,
  input  logic                         S_AXIS_USER,
  output logic                         fwr_vld,
  input  logic                         fwr_rdy,
  output logic [FDW-1:0]               fwr_dout,
  input  logic                         fwr_full,
  input  logic [FAW:0]                 fwr_cnt,
  output logic                         frame_done,
  output logic                         err_short_line,
  output logic                         err_long_line,
  output logic                         err_early_sof
);

  localparam int unsigned Lanes        = 4;
  localparam int unsigned BeatsPerLine = PIXELS_HORIZONTAL / 4;
  localparam int unsigned BeatW        = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
  localparam int unsigned LineW        = (PIXELS_VERTICAL > 1) ? $clog2(PIXELS_VERTICAL) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerLine - 1);
  localparam logic [LineW-1:0] LastLine = LineW'(PIXELS_VERTICAL - 1);

  typedef enum logic [0:0] {StWaitSof, StRun} state_e;

  state_e             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [LineW-1:0]   line_q, line_d;
  logic [FDW-1:0]     pack_q, pack_d;
  logic [FDW-1:0]     out_q, out_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic               short_q, short_d;
  logic               long_q, long_d;
  logic               sof_q, sof_d;
  logic [FDW-1:0]     word;
  logic               word_done;
  logic               accept;
  logic               end_line;

`ifdef AXIS2FIFO_LEVEL_THROTTLE_EN
  localparam logic [FAW:0] AlmostFull = (FAW + 1)'(ALMOST_FULL_LEVEL);
  logic unused_in;
  assign unused_in = ^{fwr_full, S_AXIS_TSTRB};
`else
  logic unused_in;
  assign unused_in = ^{fwr_full, fwr_cnt, S_AXIS_TSTRB};
`endif

  // Ready: stall only a beat that would complete a word while the output word is still pending.
  // An early TLAST also completes (pads) a word, so it is stalled the same way as lane 3.
  always_comb begin
    word_done     = (state_q == StRun) & ((lane_q == 2'd3) | (S_AXIS_TLAST & ~S_AXIS_USER));
    S_AXIS_TREADY = ~word_done | ~vld_q | fwr_rdy;
`ifdef AXIS2FIFO_LEVEL_THROTTLE_EN
    if (fwr_cnt >= AlmostFull) S_AXIS_TREADY = 1'b0;
`endif
  end

  assign accept = S_AXIS_TVALID & S_AXIS_TREADY;

  // Current pack register with the incoming beat dropped into its lane (first beat = MSBs).
  always_comb begin
    word = pack_q;
    for (int i = 0; i < Lanes; i++) begin
      if (lane_q == 2'(i)) begin
        word[(Lanes - 1 - i) * AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = S_AXIS_TDATA;
      end
    end
  end

  // Next-state: frame/line tracking, packing, output handoff and status pulses.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    beat_d   = beat_q;
    line_d   = line_q;
    pack_d   = pack_q;
    out_d    = out_q;
    vld_d    = vld_q & ~fwr_rdy;
    done_d   = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    sof_d    = 1'b0;
    end_line = S_AXIS_TLAST | (beat_q == LastBeat);
    if (accept) begin
      unique case (state_q)
        StWaitSof: begin
          if (S_AXIS_USER) begin
            pack_d  = {S_AXIS_TDATA, {(FDW - AXIS_DATA_WIDTH){1'b0}}};
            lane_d  = 2'd1;
            beat_d  = BeatW'(1);
            line_d  = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (S_AXIS_USER && ((line_q != '0) || (beat_q != '0))) begin
            // Restart: partial pack is dropped, a pending output word is left alone.
            sof_d  = 1'b1;
            pack_d = {S_AXIS_TDATA, {(FDW - AXIS_DATA_WIDTH){1'b0}}};
            lane_d = 2'd1;
            beat_d = BeatW'(1);
            line_d = '0;
          end else begin
            short_d = S_AXIS_TLAST & (beat_q != LastBeat);
            long_d  = ~S_AXIS_TLAST & (beat_q == LastBeat);
            if ((lane_q == 2'd3) || end_line) begin
              // Unfilled lanes of pack_q are already zero, giving the padding for short lines.
              out_d  = word;
              vld_d  = 1'b1;
              pack_d = '0;
              lane_d = 2'd0;
            end else begin
              pack_d = word;
              lane_d = lane_q + 2'd1;
            end
            if (end_line) begin
              beat_d = '0;
              if (line_q == LastLine) begin
                done_d  = 1'b1;
                line_d  = '0;
                state_d = StWaitSof;
              end else begin
                line_d = line_q + LineW'(1);
              end
            end else begin
              beat_d = beat_q + BeatW'(1);
            end
          end
        end
        default: state_d = StWaitSof;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q <= StWaitSof;
      lane_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      pack_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      pack_q  <= pack_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      short_q <= short_d;
      long_q  <= long_d;
      sof_q   <= sof_d;
    end
  end

  assign fwr_vld        = vld_q;
  assign fwr_dout       = out_q;
  assign frame_done     = done_q;
  assign err_short_line = short_q;
  assign err_long_line  = long_q;
  assign err_early_sof  = sof_q;

endmodule

// File: tb/tb_axis2fifo_packer.sv
// Testbench for axis2fifo_packer: directed geometry cases plus a random beat stream,
// checked against a beat-level reference model of the packing and line/frame rules.
module tb_axis2fifo_packer;

  localparam int PH  = 16;
  localparam int PV  = 2;
  localparam int BPL = PH / 4;
  localparam int AFL = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tvalid = 1'b0;
  logic         tready;
  logic [31:0]  tdata = '0;
  logic [3:0]   tstrb = 4'hf;
  logic         tlast = 1'b0;
  logic         tuser = 1'b0;
  logic         fwr_vld;
  logic         fwr_rdy = 1'b1;
  logic [127:0] fwr_dout;
  logic         fwr_full = 1'b0;
  logic [8:0]   fwr_cnt = '0;
  logic         frame_done, err_short, err_long, err_sof;

  always #5 clk = ~clk;

  axis2fifo_packer #(
    .FDW(128), .FAW(8), .AXIS_DATA_WIDTH(32),
    .PIXELS_HORIZONTAL(PH), .PIXELS_VERTICAL(PV), .ALMOST_FULL_LEVEL(AFL)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast), .S_AXIS_USER(tuser),
    .fwr_vld(fwr_vld), .fwr_rdy(fwr_rdy), .fwr_dout(fwr_dout), .fwr_full(fwr_full),
    .fwr_cnt(fwr_cnt), .frame_done(frame_done), .err_short_line(err_short),
    .err_long_line(err_long), .err_early_sof(err_sof)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks beats of the current line and lanes of the current word.
  logic [127:0] exp_q[$];
  logic [31:0]  m_lanes[$];
  int m_active = 0, m_line = 0, m_beat = 0;
  int e_done = 0, e_short = 0, e_long = 0, e_sof = 0;
  int c_done = 0, c_short = 0, c_long = 0, c_sof = 0;
  bit rnd_rdy = 0;

  function automatic void push_word();
    logic [127:0] w = '0;
    for (int i = 0; i < m_lanes.size(); i++) w[127 - 32 * i -: 32] = m_lanes[i];
    exp_q.push_back(w);
    m_lanes.delete();
  endfunction

  function automatic void model_accept(input logic [31:0] d, input bit last, input bit user);
    bit end_line;
    if (m_active == 0) begin
      if (user) begin
        m_active = 1; m_line = 0; m_beat = 1;
        m_lanes.delete(); m_lanes.push_back(d);
      end
    end else if (user && !(m_line == 0 && m_beat == 0)) begin
      e_sof++;
      m_line = 0; m_beat = 1;
      m_lanes.delete(); m_lanes.push_back(d);
    end else begin
      m_lanes.push_back(d);
      m_beat++;
      end_line = last || (m_beat == BPL);
      if (last && m_beat < BPL) e_short++;
      if (!last && m_beat == BPL) e_long++;
      if (m_lanes.size() == 4 || end_line) push_word();
      if (end_line) begin
        m_beat = 0;
        m_line++;
        if (m_line == PV) begin
          e_done++; m_active = 0; m_line = 0;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete(); m_lanes.delete();
    m_active = 0; m_line = 0; m_beat = 0;
  endfunction

  // Output monitor: delivered words, hold-while-stalled, pulse counting.
  bit prev_pend = 0;
  logic [127:0] prev_dout = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_pend) begin
        check("hold_vld", 128'(fwr_vld), 128'(1));
        check("hold_dout", fwr_dout, prev_dout);
      end
      if (fwr_vld && fwr_rdy) begin
        if (exp_q.size() == 0) check("extra_word", 128'(fwr_vld), 128'(0));
        else check("word", fwr_dout, exp_q.pop_front());
      end
      if (frame_done) c_done++;
      if (err_short) c_short++;
      if (err_long) c_long++;
      if (err_sof) c_sof++;
    end
    prev_pend = fwr_vld && !fwr_rdy && !rst;
    prev_dout = fwr_dout;
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [31:0] d, input bit last, input bit user);
    int n = 0;
    bit acc = 0;
    tvalid = 1'b1; tdata = d; tlast = last; tuser = user;
    while (!acc && n < 200) begin
      if (rnd_rdy) fwr_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = tready;
      @(posedge clk); #1;
      n++;
    end
    if (acc) model_accept(d, last, user);
    else check("accept_timeout", 128'(n), 128'(0));
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rnd_rdy) fwr_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic std_frame(input logic [31:0] base, input bit long0);
    for (int i = 0; i < 8; i++) send_beat(base + 32'(i), (i == 7) || (i == 3 && !long0), i == 0);
  endtask

  task automatic drain();
    int n = 0;
    fwr_rdy = 1'b1;
    while ((exp_q.size() != 0 || fwr_vld) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("drain_timeout", 128'(n), 128'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_done"}, 128'(c_done), 128'(e_done));
    check({tag, "_short"}, 128'(c_short), 128'(e_short));
    check({tag, "_long"}, 128'(c_long), 128'(e_long));
    check({tag, "_sof"}, 128'(c_sof), 128'(e_sof));
    check({tag, "_left"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_vld", 128'(fwr_vld), 128'(0));
    check("rst_dout", fwr_dout, 128'(0));
    check("rst_tready", 128'(tready), 128'(1));
    check("rst_pulses", 128'({frame_done, err_short, err_long, err_sof}), 128'(0));
    @(posedge clk); #1;

    // Basic frame
    std_frame(32'h1, 1'b0);
    drain();
    check_counts("t1");

    // Junk before SOF
    send_beat(32'hAA, 1'b0, 1'b0);
    send_beat(32'hBB, 1'b0, 1'b0);
    std_frame(32'h1, 1'b0);
    drain();
    check_counts("t2");

    // Short line 0
    send_beat(32'h1, 1'b0, 1'b1);
    send_beat(32'h2, 1'b1, 1'b0);
    @(negedge clk);
    check("short_pulse", 128'(err_short), 128'(1));
    check("short_word", fwr_dout, 128'h00000001_00000002_00000000_00000000);
    @(negedge clk);
    check("short_pulse_end", 128'(err_short), 128'(0));
    @(posedge clk); #1;
    for (int i = 3; i <= 6; i++) send_beat(32'(i), i == 6, 1'b0);
    drain();
    check_counts("t3");

    // Output stall at lane 3
    fwr_rdy = 1'b0;
    for (int i = 1; i <= 7; i++) send_beat(32'(i), i == 4, i == 1);
    tvalid = 1'b1; tdata = 32'h8; tlast = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall_tready", 128'(tready), 128'(0));
      check("stall_vld", 128'(fwr_vld), 128'(1));
      check("stall_dout", fwr_dout, 128'h00000001_00000002_00000003_00000004);
    end
    @(posedge clk); #1;
    fwr_rdy = 1'b1;
    send_beat(32'h8, 1'b1, 1'b0);
    drain();
    check_counts("t4");

    // Early SOF on line 1 beat 2
    for (int i = 1; i <= 6; i++) send_beat(32'(i), i == 4, i == 1);
    send_beat(32'h9, 1'b0, 1'b1);
    @(negedge clk);
    check("sof_pulse", 128'(err_sof), 128'(1));
    @(posedge clk); #1;
    for (int i = 10; i <= 16; i++) send_beat(32'(i), i == 12 || i == 16, 1'b0);
    drain();
    check_counts("t5");

    // Long line 0
    std_frame(32'h20, 1'b1);
    drain();
    check_counts("long");

    // Reset with a pending word and a partial pack
    fwr_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) send_beat(32'(i), i == 4, i == 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst2_vld", 128'(fwr_vld), 128'(0));
    check("rst2_dout", fwr_dout, 128'(0));
    check("rst2_tready", 128'(tready), 128'(1));
    @(posedge clk); #1;
    fwr_rdy = 1'b1;
    std_frame(32'h100, 1'b0);
    drain();
    check_counts("rst2");

    // Random stream with random FIFO back-pressure
    rnd_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 2));
      send_beat($urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end
    rnd_rdy = 0;
    drain();
    check_counts("rand");

`ifdef AXIS2FIFO_LEVEL_THROTTLE_EN
    fwr_cnt = 9'(AFL);
    @(negedge clk);
    check("thr_at_level", 128'(tready), 128'(0));
    fwr_cnt = 9'(AFL - 1);
    @(negedge clk);
    check("thr_below", 128'(tready), 128'(1));
    fwr_cnt = '0;
    @(posedge clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
